ctrl_unit_param: RTL
====================

Name: ctrl_unit_param

Overview:
- Parametrised successor to the team's 4-bit multi-cycle CPU control unit: Moore FSM sequencing fetch/decode/execute for a small accumulator datapath.
- Generalises opcode width, register-file depth and ALU mode width; adds per-register load enables, zero-flag conditional jump, a valid/ready output handshake, a run/pause gate and illegal-opcode flagging.
- Sits between the IR/PC and the datapath; drives every load/select strobe.

Parameters:
- OPW, 4, opcode width; opcodes below are zero-extended to OPW.
- NREG, 4, datapath registers (>=2); RIDX_W = clog2(NREG) is derived locally.
- SELW, 2, ALU mode select width (>=2).

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- IR_CU  in  OPW  opcode field of the instruction register
- IR_Idx  in  RIDX_W  register-index field of the instruction register
- Run  in  1  1 = execute; 0 = hold in START (replaces StopProgram)
- Zero  in  1  ALU zero flag from the datapath flag register
- Out_Ready  in  1  output consumer ready
- IRload  out  1  load IR
- PCload  out  1  load PC
- Jump_SelMode  out  1  PC mux: 0 = PC+1, 1 = jump target
- In_Sel  out  1  register write mux: 1 = external input, 0 = ALU
- RegLoad  out  NREG  one-hot register write enable
- FlagLoad  out  1  load the zero-flag register
- Sel_Mode  out  SELW  ALU operation
- Out_Valid  out  1  output data valid
- Illegal  out  1  one-cycle pulse on an undefined opcode
- Halt  out  1  processor halted
- OUTPUT  out  3  current state encoding (debug)

Behaviour:
- Reset (async, Reset_n=0): state=START immediately; all outputs 0, including mid-handshake (Out_Valid drops).
- States: START=0, FETCH=1, DECODE=2, EXEC=3, OUTW=4, HALT=5. Codes 6 and 7 go to HALT on the next edge.
- All outputs are combinational from the registered state plus IR_CU, IR_Idx and Zero. No output is registered. An output not listed for a state is 0.
- START: no strobes. Next state is FETCH if Run=1, else START.
- FETCH: IRload=1, PCload=1, Jump_SelMode=0. Next state DECODE.
- DECODE: no strobes. Next state: OUTW if opcode=6; HALT if opcode=9; else EXEC.
- EXEC (next state START):
  - opcode 0, NOP: no strobes.
  - opcode 1, LOAD: In_Sel=1, RegLoad[IR_Idx]=1.
  - opcodes 2/3/4/5, ADD/SUB/AND/OR: Sel_Mode=0/1/2/3 zero-extended to SELW; RegLoad[IR_Idx]=1; FlagLoad=1; In_Sel=0.
  - opcode 7, JMP: PCload=1, Jump_SelMode=1.
  - opcode 8, JZ: Jump_SelMode=1; PCload=Zero.
  - any other opcode: Illegal=1 for this single EXEC cycle, otherwise NOP.
- OUTW: Out_Valid=1. Stays in OUTW while Out_Ready=0. Moves to START on the first edge where Out_Ready=1. Out_Ready already high on entry still takes the full OUTW cycle, so Out_Valid is high for at least 1 cycle.
- HALT: Halt=1. Stays in HALT until reset; Run is ignored.
- Latency:
  - Non-OUT instruction: 4 cycles (START to EXEC).
  - OUT: 3 + N cycles, where N >= 1 is the OUTW wait.
  - HALT asserts on the 4th cycle.
- Run=0 is sampled only in START. An instruction already fetched completes.
- IR_Idx >= NREG: RegLoad all zeros; Illegal=1 in EXEC.
- OUTPUT = state, zero-extended to 3 bits.

Optional Feature:
- Macro: CTRL_UNIT_PARAM_INSTR_COUNT_EN.
- Defined:
  - Adds output port Instr_Count[15:0].
  - Increments on each transition into START from EXEC or OUTW.
  - Saturates at 16'hFFFF; does not count HALT.
  - Async reset to 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset_n=0 mid-EXEC of ADD → same cycle: OUTPUT=0, RegLoad=0, FlagLoad=0. After release with Run=1 → OUTPUT sequence 0,1,2,3.
- IR_CU=1, IR_Idx=2, NREG=4 → in EXEC: In_Sel=1, RegLoad=4'b0100, for exactly 1 cycle; OUTPUT=3.
- IR_CU=3, IR_Idx=1 → EXEC: Sel_Mode=2'b01, RegLoad=4'b0010, FlagLoad=1. IR_CU=8 with Zero=0 → PCload=0, Jump_SelMode=1. Same with Zero=1 → PCload=1.
- IR_CU=6, Out_Ready held 0 for 5 cycles then 1 → Out_Valid high for exactly 6 cycles, then OUTPUT=0. Repeat with Out_Ready=1 throughout → Out_Valid high for 1 cycle.
- IR_CU=4'hC → Illegal=1 for one cycle, no strobes. IR_CU=9 → Halt=1 from the 4th cycle and stays 1 over 20 cycles with Run toggling.
- Run=0 in START → OUTPUT stays 0, IRload=0. With CTRL_UNIT_PARAM_INSTR_COUNT_EN defined, 3 NOPs plus 1 OUT → Instr_Count=4.

Source files
------------

// File: rtl/ctrl_unit_param.sv
// Parametrised multi-cycle control unit: Moore FSM (START/FETCH/DECODE/EXEC/OUTW/HALT)
// driving datapath strobes. Define CTRL_UNIT_PARAM_INSTR_COUNT_EN to add Instr_Count.
module ctrl_unit_param #(
  parameter int OPW  = 4,
  parameter int NREG = 4,
  parameter int SELW = 2,
  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [OPW-1:0]    IR_CU,
  input  logic [RIDX_W-1:0] IR_Idx,
  input  logic              Run,
  input  logic              Zero,
  input  logic              Out_Ready,
  output logic              IRload,
  output logic              PCload,
  output logic              Jump_SelMode,
  output logic              In_Sel,
  output logic [NREG-1:0]   RegLoad,
  output logic              FlagLoad,
  output logic [SELW-1:0]   Sel_Mode,
  output logic              Out_Valid,
  output logic              Illegal,
  output logic              Halt,
  output logic [2:0]        OUTPUT
`ifdef CTRL_UNIT_PARAM_INSTR_COUNT_EN
  , output logic [15:0]     Instr_Count
`endif
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_OUTW   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Widen the fields once so opcode/index compares need no per-site casts.
  logic [31:0] op32, idx32;
  logic        idx_ok;
  logic [NREG-1:0] reg_sel;

  assign op32   = 32'(IR_CU);
  assign idx32  = 32'(IR_Idx);
  assign idx_ok = (idx32 < 32'(NREG));

  always_comb begin
    reg_sel = '0;
    if (idx_ok) reg_sel[IR_Idx] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_START;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    IRload       = 1'b0;
    PCload       = 1'b0;
    Jump_SelMode = 1'b0;
    In_Sel       = 1'b0;
    RegLoad      = '0;
    FlagLoad     = 1'b0;
    Sel_Mode     = '0;
    Out_Valid    = 1'b0;
    Illegal      = 1'b0;
    Halt         = 1'b0;
    unique case (state_q)
      ST_START: if (Run) state_d = ST_FETCH;
      ST_FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if      (op32 == 32'd6) state_d = ST_OUTW;
        else if (op32 == 32'd9) state_d = ST_HALT;
        else                    state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_START;
        Illegal = !idx_ok;
        case (op32)
          32'd0: ;
          32'd1: begin
            In_Sel  = 1'b1;
            RegLoad = reg_sel;
          end
          32'd2, 32'd3, 32'd4, 32'd5: begin
            Sel_Mode = SELW'(op32 - 32'd2);
            RegLoad  = reg_sel;
            FlagLoad = 1'b1;
          end
          32'd7: begin
            PCload       = 1'b1;
            Jump_SelMode = 1'b1;
          end
          32'd8: begin
            Jump_SelMode = 1'b1;
            PCload       = Zero;
          end
          default: Illegal = 1'b1;
        endcase
      end
      ST_OUTW: begin
        Out_Valid = 1'b1;
        if (Out_Ready) state_d = ST_START;
      end
      ST_HALT: Halt = 1'b1;
      default: state_d = ST_HALT;
    endcase
  end

  assign OUTPUT = state_q;

`ifdef CTRL_UNIT_PARAM_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count completed instructions only; HALT never returns to START.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_START && (state_q == ST_EXEC || state_q == ST_OUTW) &&
        cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign Instr_Count = cnt_q;
`endif

endmodule
